seq_shift_engine: RTL and testbench
===================================

// Module: seq_shift_engine
// PURPOSE
// - Multi-cycle shift engine, one bit position per clock, directly upstream of the 2:1 direction-select mux.
// - Accepts a WIDTH-bit operand, shift amount and direction over a valid/ready handshake.
// - Produces both the left-shifted and right-shifted result plus the registered direction.
// - The downstream mux uses the direction as its select (1 = left).
// PARAMETERS
// - WIDTH   4                     operand width; matches the downstream mux data width
// - SHAMT_W $clog2(WIDTH) (=2)    shift-amount width; max shift is WIDTH-1
// - ROTATE  0                     0 = zero-fill logical shift, 1 = rotate
// PORTS
// - clk        in   1        single clock, all state on rising edge
// - rst        in   1        synchronous, active-high reset
// - in_valid   in   1        request valid
// - in_ready   out  1        engine can accept (high only in S_IDLE)
// - in_data    in   WIDTH    operand
// - in_shamt   in   SHAMT_W  shift amount
// - in_dir     in   1        1 = left, 0 = right; passed through to out_dir
// - out_valid  out  1        results valid (high only in S_DONE)
// - out_ready  in   1        consumer accepts result
// - out_left   out  WIDTH    operand shifted left by shamt (drives mux in1)
// - out_right  out  WIDTH    operand shifted right by shamt (drives mux in0)
// - out_dir    out  1        registered in_dir (drives mux select)
// - busy       out  1        high in S_SHIFT or S_DONE
// BEHAVIOUR
// - Reset values:
//   - state = S_IDLE, in_ready = 1, out_valid = 0, busy = 0.
//   - out_left = out_right = 0, out_dir = 0, shift count = 0.
// - S_IDLE: in_ready = 1. On in_valid & in_ready:
//   - left_reg, right_reg <= in_data; cnt <= in_shamt; dir_reg <= in_dir.
//   - Next state is S_DONE if in_shamt == 0, else S_SHIFT.
// - S_SHIFT, each cycle:
//   - left_reg <= left_reg << 1; right_reg <= right_reg >> 1; vacated bit = 0.
//   - With ROTATE = 1, the vacated bit takes the bit shifted out instead.
//   - cnt <= cnt - 1. When cnt == 1 (last step), go to S_DONE.
// - S_DONE:
//   - out_valid = 1; out_left, out_right and out_dir are held stable.
//   - On out_ready, go to S_IDLE.
//   - No skid: a new request is accepted no earlier than the cycle after S_IDLE is re-entered.
// - Latency: out_valid asserts shamt+1 cycles after the accept edge (shamt = 0 gives 1 cycle).
// - Throughput: one result per shamt+2 cycles minimum with out_ready tied high.
// - Boundary conditions:
//   - in_valid while busy is ignored, not queued; in_data may change freely.
//   - out_ready while not in S_DONE is ignored.
//   - The shift amount is bounded by SHAMT_W, so no over-shift case exists.
//   - rst at any state, including mid-S_SHIFT: next cycle is S_IDLE with all reset values; the partial result is discarded.
// - Outputs out_left/out_right/out_dir are driven directly from registers: no combinational in->out paths.
// - out_valid and in_ready are decoded from state only.
// STRUCTURE
// - Shared package shift_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t.
//   - localparam DIR_LEFT = 1'b1, DIR_RIGHT = 1'b0.
// - Single module implementation: one always_ff for state/datapath, one always_comb for next state.
//   No sub-module is required.
// - The downstream 2:1 mux is instantiated beside this block at the shifter top level, not inside it.
// TESTING (WIDTH=4)
// - Reset: rst high for 2 cycles -> in_ready=1, out_valid=0, busy=0, outputs 4'b0000.
// - Left, zero-fill: data=1011, shamt=2, dir=1 -> 3 cycles after accept out_valid=1, out_left=1100, out_right=0010, out_dir=1.
// - Zero shift: data=0110, shamt=0, dir=0 -> out_valid 1 cycle after accept, out_left=out_right=0110, out_dir=0.
// - Backpressure: out_ready low 5 cycles in S_DONE -> outputs stable, in_ready=0; a second in_valid is ignored. Release -> S_IDLE next cycle.
// - Rotate (ROTATE=1): data=1001, shamt=1 -> out_left=0011, out_right=1100; shamt=3 -> out_left=1100, out_right=0011.
// - Reset mid-shift: data=1111, shamt=3, rst on 2nd S_SHIFT cycle -> next cycle S_IDLE, outputs 0000, no out_valid pulse.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential shift engine.
// Imported by seq_shift_engine and the shifter top level.
package shift_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } shift_state_t;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/seq_shift_engine.sv
// Multi-cycle shifter, one bit position per clock.
// Feeds left/right results and registered direction to a 2:1 mux.
module seq_shift_engine
   import shift_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int ROTATE  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_dir,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_left,
   output logic [WIDTH-1:0]   out_right,
   output logic               out_dir,
   output logic               busy
);

   shift_state_t       state_q, state_d;
   logic [WIDTH-1:0]   left_q;
   logic [WIDTH-1:0]   right_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               dir_q;
   logic               lfill;
   logic               rfill;

   assign lfill = (ROTATE != 0) ? left_q[WIDTH-1] : 1'b0;
   assign rfill = (ROTATE != 0) ? right_q[0] : 1'b0;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT)
                    || (state_q == S_DONE);
   assign out_left  = left_q;
   assign out_right = right_q;
   assign out_dir   = dir_q;

   // Next-state decode; requests outside S_IDLE are dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = (in_shamt == '0) ? S_DONE
                                          : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, operand load and one-bit-per-cycle shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         left_q  <= '0;
         right_q <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_RIGHT;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && in_valid) begin
            left_q  <= in_data;
            right_q <= in_data;
            cnt_q   <= in_shamt;
            dir_q   <= in_dir;
         end else if (state_q == S_SHIFT) begin
            left_q  <= {left_q[WIDTH-2:0], lfill};
            right_q <= {rfill, right_q[WIDTH-1:1]};
            cnt_q   <= cnt_q - SHAMT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_shift_engine.sv
// Bench for seq_shift_engine: zero-fill and rotate instances
// driven in lockstep, results checked through a scoreboard queue.
module tb_seq_shift_engine;

   localparam int W  = 4;
   localparam int SW = 2;

   typedef struct {
      logic [W-1:0]  data;
      logic [SW-1:0] shamt;
      logic          dir;
      logic [W-1:0]  l0;
      logic [W-1:0]  r0;
      logic [W-1:0]  l1;
      logic [W-1:0]  r1;
   } vec_t;

   typedef struct {
      logic [W-1:0] l0;
      logic [W-1:0] r0;
      logic [W-1:0] l1;
      logic [W-1:0] r1;
      logic         dir;
      int           lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_shamt;
   logic          in_dir;
   logic          out_ready;

   logic          rdy0, ov0, dir0, busy0;
   logic [W-1:0]  l0, r0;
   logic          rdy1, ov1, dir1, busy1;
   logic [W-1:0]  l1, r1;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vt[8];

   always #5 clk = ~clk;

   seq_shift_engine #(.WIDTH(W), .ROTATE(0)) u0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(rdy0),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_dir(in_dir),
      .out_valid(ov0), .out_ready(out_ready),
      .out_left(l0), .out_right(r0),
      .out_dir(dir0), .busy(busy0)
   );

   seq_shift_engine #(.WIDTH(W), .ROTATE(1)) u1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(rdy1),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_dir(in_dir),
      .out_valid(ov1), .out_ready(out_ready),
      .out_left(l1), .out_right(r1),
      .out_dir(dir1), .busy(busy1)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, " rdy0"}, 32'(rdy0), 1);
      chk({nm, " ov0"}, 32'(ov0), 0);
      chk({nm, " busy0"}, 32'(busy0), 0);
      chk({nm, " rdy1"}, 32'(rdy1), 1);
      chk({nm, " ov1"}, 32'(ov1), 0);
      chk({nm, " busy1"}, 32'(busy1), 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " l0"}, 32'(l0), 0);
      chk({nm, " r0"}, 32'(r0), 0);
      chk({nm, " l1"}, 32'(l1), 0);
      chk({nm, " r1"}, 32'(r1), 0);
      chk({nm, " dir"}, 32'({dir1, dir0}), 0);
   endtask

   // Accept one request and push its expected result.
   task automatic issue(input vec_t v);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!rdy0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy0) chk("ready timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = v.data;
      in_shamt = v.shamt;
      in_dir   = v.dir;
      @(posedge clk);
      e.l0  = v.l0;
      e.r0  = v.r0;
      e.l1  = v.l1;
      e.r1  = v.r1;
      e.dir = v.dir;
      e.lat = int'(v.shamt) + 1;
      sb.push_back(e);
   endtask

   // Wait for out_valid, then pop and compare.
   task automatic collect(input string nm);
      exp_t e;
      int lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~in_data;
      while (!ov0 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         chk({nm, " sb empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      chk({nm, " ov0"}, 32'(ov0), 1);
      chk({nm, " ov1"}, 32'(ov1), 1);
      chk({nm, " lat"}, 32'(lat), 32'(e.lat));
      chk({nm, " l0"}, 32'(l0), 32'(e.l0));
      chk({nm, " r0"}, 32'(r0), 32'(e.r0));
      chk({nm, " l1"}, 32'(l1), 32'(e.l1));
      chk({nm, " r1"}, 32'(r1), 32'(e.r1));
      chk({nm, " dir0"}, 32'(dir0), 32'(e.dir));
      chk({nm, " dir1"}, 32'(dir1), 32'(e.dir));
      chk({nm, " rdy"}, 32'(rdy0), 0);
   endtask

   initial begin
      vec_t v;
      logic [W-1:0] hl0, hr0;
      logic         sawv;

      vt[0] = '{4'b1011, 2'd2, 1'b1,
                4'b1100, 4'b0010, 4'b1110, 4'b1110};
      vt[1] = '{4'b0110, 2'd0, 1'b0,
                4'b0110, 4'b0110, 4'b0110, 4'b0110};
      vt[2] = '{4'b1001, 2'd1, 1'b1,
                4'b0010, 4'b0100, 4'b0011, 4'b1100};
      vt[3] = '{4'b1001, 2'd3, 1'b0,
                4'b1000, 4'b0001, 4'b1100, 4'b0011};
      vt[4] = '{4'b0001, 2'd3, 1'b1,
                4'b1000, 4'b0000, 4'b1000, 4'b0010};
      vt[5] = '{4'b1111, 2'd1, 1'b0,
                4'b1110, 4'b0111, 4'b1111, 4'b1111};
      vt[6] = '{4'b0101, 2'd2, 1'b1,
                4'b0100, 4'b0001, 4'b0101, 4'b0101};
      vt[7] = '{4'b1100, 2'd1, 1'b0,
                4'b1000, 4'b0110, 4'b1001, 4'b0110};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_dir    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         issue(vt[i]);
         collect($sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d idle", i),
             32'({rdy1, rdy0}), 3);
      end

      out_ready = 1'b0;
      issue(vt[0]);
      collect("bp");
      hl0 = l0;
      hr0 = r0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 3);
         in_shamt = 2'd0;
         in_dir   = 1'b0;
         @(negedge clk);
         chk("bp hold ov", 32'({ov1, ov0}), 3);
         chk("bp hold rdy", 32'({rdy1, rdy0}), 0);
         chk("bp hold busy", 32'(busy0), 1);
         chk("bp hold l0", 32'(l0), 32'(hl0));
         chk("bp hold r0", 32'(r0), 32'(hr0));
         chk("bp hold l1", 32'(l1), 32'(vt[0].l1));
         chk("bp hold dir", 32'(dir0), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk_idle("bp release");
      chk("bp no extra", 32'(sb.size()), 0);

      v = '{4'b1111, 2'd3, 1'b1,
            4'b0, 4'b0, 4'b0, 4'b0};
      in_valid = 1'b1;
      in_data  = v.data;
      in_shamt = v.shamt;
      in_dir   = v.dir;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rm shift1 busy", 32'(busy0), 1);
      @(negedge clk);
      chk("rm shift2 ov", 32'(ov0), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle("rm");
      chk_zero("rm");
      sawv = 1'b0;
      repeat (5) begin
         @(negedge clk);
         sawv = sawv | ov0 | ov1;
      end
      chk("rm no pulse", 32'(sawv), 0);
      chk("rm still idle", 32'(rdy0), 1);

      out_ready = 1'b0;
      issue(vt[4]);
      collect("after rm");
      out_ready = 1'b1;
      @(negedge clk);
      chk_idle("final");
      chk("sb drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
